// File: rtl/dmem_responder.sv
// Single-word data-memory responder: one outstanding access, fixed added latency,
// byte-lane stores, and fault reporting for misaligned or out-of-range addresses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_be,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [7:0]  o_err_count
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    cnt_reg, cnt_next;
  logic          we_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   wdata_reg;
  logic [3:0]    be_reg;
  logic          err_reg;
  logic [7:0]    err_count_reg;

  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   ram_q;

  logic          accept;
  logic          commit;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic          acc_fault;
  logic [AW-1:0] acc_idx;

  // With zero added latency the access commits on its own acceptance edge, so the
  // live request inputs stand in for the not-yet-captured registers while IDLE.
  always_comb begin
    if (state_reg == IDLE) begin
      acc_we    = i_req_we;
      acc_addr  = i_req_addr;
      acc_wdata = i_req_wdata;
      acc_be    = i_req_be;
    end else begin
      acc_we    = we_reg;
      acc_addr  = addr_reg;
      acc_wdata = wdata_reg;
      acc_be    = be_reg;
    end
  end

  assign acc_fault = (acc_addr[1:0] != 2'b00) ||
                     ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
  assign acc_idx   = acc_addr[AW+1:2];

  assign accept = (state_reg == IDLE) && i_req_valid;
  assign commit = !i_rst && ((accept && (WAIT_CYCLES == 0)) ||
                             ((state_reg == WAIT) && (cnt_reg == 4'd0)));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (i_req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      RESP: begin
        if (i_rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      we_reg        <= 1'b0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      be_reg        <= 4'd0;
      err_reg       <= 1'b0;
      err_count_reg <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        we_reg    <= i_req_we;
        addr_reg  <= i_req_addr;
        wdata_reg <= i_req_wdata;
        be_reg    <= i_req_be;
      end
      if (commit) begin
        err_reg <= acc_fault;
        if (acc_fault && (err_count_reg != 8'hFF)) err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  // Storage is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge i_clk) begin
    if (commit && !acc_fault) begin
      if (acc_we) begin
        for (int lane = 0; lane < 4; lane++) begin
          if (acc_be[lane]) mem[acc_idx][8*lane +: 8] <= acc_wdata[8*lane +: 8];
        end
      end
      ram_q <= mem[acc_idx];
    end
  end

  assign o_req_ready = (state_reg == IDLE) && !i_rst;
  assign o_rsp_valid = (state_reg == RESP);
  assign o_rsp_err   = o_rsp_valid && err_reg;
  assign o_rsp_rdata = (o_rsp_valid && !we_reg && !err_reg) ? ram_q : 32'd0;
  assign o_err_count = err_count_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=1 instance for function and reset,
// and a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dmem_responder;

  logic        clk;
  logic        rst;

  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  err_count;

  logic        req_valid1, req_ready1, req_we1;
  logic [31:0] req_addr1, req_wdata1;
  logic [3:0]  req_be1;
  logic        rsp_valid1, rsp_ready1, rsp_err1;
  logic [31:0] rsp_rdata1;
  logic [7:0]  err_count1;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .i_req_be(req_be),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err), .o_err_count(err_count)
  );

  dmem_responder #(.DEPTH_WORDS(16), .WAIT_CYCLES(0)) dut0 (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid1), .o_req_ready(req_ready1), .i_req_we(req_we1),
    .i_req_addr(req_addr1), .i_req_wdata(req_wdata1), .i_req_be(req_be1),
    .o_rsp_valid(rsp_valid1), .i_rsp_ready(rsp_ready1), .o_rsp_rdata(rsp_rdata1),
    .o_rsp_err(rsp_err1), .o_err_count(err_count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one request on the WAIT_CYCLES=1 instance, starting at a falling edge.
  // lat counts rising edges from acceptance until the response is seen (1+WAIT_CYCLES).
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output int lat, output logic [31:0] rdata,
                       output logic err);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = 32'hX5X5X5X5;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    $display("txn we=%0b addr=%08h wdata=%08h be=%04b -> lat=%0d rdata=%08h err=%0b cnt=%0d",
             we, addr, wdata, be, lat, rdata, err, err_count);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low got=%0b want=0", req_ready); end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b want=0", rsp_valid); end
    checks++;
    if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%08h want=0", rsp_rdata); end
    checks++;
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%0b want=0", rsp_err); end
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL reset_errcnt got=%0d want=0", err_count); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high got=%0b want=1", req_ready); end
    $display("reset done ready=%0b", req_ready);
  endtask

  task automatic test_store_load();
    int lat;
    logic [31:0] rd;
    logic e;
    issue(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, lat, rd, e);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL store_latency got=%0d want=2", lat); end
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL store_rdata got=%08h want=0", rd); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL store_err got=%0b want=0", e); end
    issue(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, e);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL load_latency got=%0d want=2", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got=%08h want=deadbeef", rd); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL load_err got=%0b want=0", e); end
  endtask

  task automatic test_byte_enable();
    int lat;
    logic [31:0] rd;
    logic e;
    issue(1'b1, 32'h10, 32'h00AA0055, 4'b0101, lat, rd, e);
    issue(1'b0, 32'h10, 32'h0, 4'b1111, lat, rd, e);
    checks++;
    if (rd !== 32'hDEAABE55) begin errors++; $display("FAIL be_rdata got=%08h want=deaabe55", rd); end
    // be=0000 is a legal no-op store
    issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, rd, e);
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL be0_err got=%0b want=0", e); end
    issue(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, e);
    checks++;
    if (rd !== 32'hDEAABE55) begin errors++; $display("FAIL be0_rdata got=%08h want=deaabe55", rd); end
  endtask

  task automatic test_errors();
    int lat;
    logic [31:0] rd;
    logic e;
    issue(1'b0, 32'h13, 32'h0, 4'b0000, lat, rd, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL misalign_err got=%0b want=1", e); end
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL misalign_rdata got=%08h want=0", rd); end
    checks++;
    if (err_count !== 8'd1) begin errors++; $display("FAIL misalign_cnt got=%0d want=1", err_count); end
    issue(1'b0, 32'h1000, 32'h0, 4'b0000, lat, rd, e);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL range_err got=%0b want=1", e); end
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL range_rdata got=%08h want=0", rd); end
    checks++;
    if (err_count !== 8'd2) begin errors++; $display("FAIL range_cnt got=%0d want=2", err_count); end
    // faulted store must not write: index bits of 0x1010 alias word 0x10 >> 2 = 4
    issue(1'b1, 32'h1010, 32'h12345678, 4'b1111, lat, rd, e);
    checks++;
    if (err_count !== 8'd3) begin errors++; $display("FAIL fault_store_cnt got=%0d want=3", err_count); end
    issue(1'b0, 32'h10, 32'h0, 4'b0000, lat, rd, e);
    checks++;
    if (rd !== 32'hDEAABE55) begin errors++; $display("FAIL after_err_rdata got=%08h want=deaabe55", rd); end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [31:0] held;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'h10;
    req_be    = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL bp_latency got=%0d want=2", lat); end
    held = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      checks++;
      if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc=%0d got=%0b want=1", i, rsp_valid); end
      checks++;
      if (rsp_rdata !== 32'hDEAABE55) begin errors++; $display("FAIL bp_rdata cyc=%0d got=%08h want=deaabe55", i, rsp_rdata); end
      checks++;
      if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%0b want=0", i, req_ready); end
      $display("bp cyc=%0d valid=%0b rdata=%08h ready=%0b", i, rsp_valid, rsp_rdata, req_ready);
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%0b want=0", rsp_valid); end
    checks++;
    if (rsp_rdata !== 32'd0) begin errors++; $display("FAIL bp_idle_rdata got=%08h want=0 (held %08h)", rsp_rdata, held); end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b want=1", req_ready); end
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    rsp_ready1 = 1'b1;
    req_valid1 = 1'b1;
    req_we1    = 1'b1;
    req_addr1  = 32'h0;
    req_wdata1 = 32'h0;
    req_be1    = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      if (req_ready1) accepts++;
      checks++;
      if (req_ready1 !== (i % 2 == 0)) begin errors++; $display("FAIL b2b_ready cyc=%0d got=%0b want=%0b", i, req_ready1, (i % 2 == 0)); end
      checks++;
      if (rsp_valid1 !== (i % 2 == 1)) begin errors++; $display("FAIL b2b_valid cyc=%0d got=%0b want=%0b", i, rsp_valid1, (i % 2 == 1)); end
      $display("b2b cyc=%0d ready=%0b valid=%0b", i, req_ready1, rsp_valid1);
      @(negedge clk);
    end
    req_valid1 = 1'b0;
    checks++;
    if (accepts !== 5) begin errors++; $display("FAIL b2b_accepts got=%0d want=5", accepts); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] rd;
    logic e;
    issue(1'b1, 32'h20, 32'h11111111, 4'b1111, lat, rd, e);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h22222222;
    req_be    = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_in_wait got=%0b want=0", req_ready); end
    rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%0b want=0", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp cyc=%0d got=%0b want=0", i, rsp_valid); end
    end
    checks++;
    if (err_count !== 8'd0) begin errors++; $display("FAIL mid_errcnt got=%0d want=0", err_count); end
    issue(1'b0, 32'h20, 32'h0, 4'b0000, lat, rd, e);
    checks++;
    if (rd !== 32'h11111111) begin errors++; $display("FAIL mid_rdata got=%08h want=11111111", rd); end
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL mid_err got=%0b want=0", e); end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    req_be     = 4'h0;
    rsp_ready  = 1'b1;
    req_valid1 = 1'b0;
    req_we1    = 1'b0;
    req_addr1  = 32'h0;
    req_wdata1 = 32'h0;
    req_be1    = 4'h0;
    rsp_ready1 = 1'b1;
    test_reset();
    test_store_load();
    test_byte_enable();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
